// File: rtl/player_motion_ctrl.sv
// Vertical-motion sequencer for the player sprite: grounded / rising / hover / falling.
// Define PLAYER_HOVER_EN to include the apex HOVER dwell; otherwise RISING exits straight to FALLING.
module player_motion_ctrl #(
    parameter int Y_WIDTH     = 4,
    parameter int START_Y     = 0,
    parameter int Y_MAX       = 15,
    parameter int MAX_RISE    = 4,
    parameter int HOVER_TICKS = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               jump,
    input  logic               platform_below,
    output logic [Y_WIDTH-1:0] y,
    output logic               on_platform,
    output logic               landed
);

    localparam int RW = $clog2(MAX_RISE + 1);
    localparam logic [Y_WIDTH-1:0] START_Y_C = START_Y[Y_WIDTH-1:0];
    localparam logic [Y_WIDTH-1:0] Y_MAX_C   = Y_MAX[Y_WIDTH-1:0];
    localparam logic [RW:0]        MAX_RISE_C = MAX_RISE[RW:0];

`ifdef PLAYER_HOVER_EN
    localparam int HW = (HOVER_TICKS > 1) ? $clog2(HOVER_TICKS) : 1;
    localparam int HOV_LOAD_I = HOVER_TICKS - 1;
    localparam logic [HW-1:0] HOV_LOAD = HOV_LOAD_I[HW-1:0];
`endif

    typedef enum logic [1:0] {
        ST_GROUNDED = 2'd0,
        ST_RISING   = 2'd1,
`ifdef PLAYER_HOVER_EN
        ST_HOVER    = 2'd2,
`endif
        ST_FALLING  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [Y_WIDTH-1:0]  y_q, y_d;
    logic                jump_q, jump_d;
    logic [RW-1:0]       rise_cnt_q, rise_cnt_d;
    logic                landed_q, landed_d;
`ifdef PLAYER_HOVER_EN
    logic [HW-1:0]       hov_cnt_q, hov_cnt_d;
`endif

    logic                jreq_s;
    logic                support_s;
    logic                y_lt_max_s;
    logic [RW:0]         rise_inc_s;

    assign jreq_s     = jump | jump_q;
    assign support_s  = platform_below | (y_q == {Y_WIDTH{1'b0}});
    assign y_lt_max_s = (y_q < Y_MAX_C);
    assign rise_inc_s = {1'b0, rise_cnt_q} + (RW + 1)'(1'b1);

    // State register: reset has priority over any tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_GROUNDED;
            y_q        <= START_Y_C;
            jump_q     <= 1'b0;
            rise_cnt_q <= {RW{1'b0}};
            landed_q   <= 1'b0;
`ifdef PLAYER_HOVER_EN
            hov_cnt_q  <= {HW{1'b0}};
`endif
        end else begin
            state_q    <= state_d;
            y_q        <= y_d;
            jump_q     <= jump_d;
            rise_cnt_q <= rise_cnt_d;
            landed_q   <= landed_d;
`ifdef PLAYER_HOVER_EN
            hov_cnt_q  <= hov_cnt_d;
`endif
        end
    end

    // Next-state logic: motion only advances on tick; between ticks only the jump latch moves.
    always_comb begin
        state_d    = state_q;
        y_d        = y_q;
        rise_cnt_d = rise_cnt_q;
        landed_d   = 1'b0;
        jump_d     = jump_q | jump;
`ifdef PLAYER_HOVER_EN
        hov_cnt_d  = hov_cnt_q;
`endif
        if (tick) begin
            jump_d = 1'b0;
            case (state_q)
                ST_GROUNDED: begin
                    if (jreq_s && y_lt_max_s) begin
                        state_d    = ST_RISING;
                        y_d        = y_q + Y_WIDTH'(1'b1);
                        rise_cnt_d = {RW{1'b0}};
                    end else if (!support_s) begin
                        state_d = ST_FALLING;
                    end else begin
                        state_d = ST_GROUNDED;
                    end
                end
                ST_RISING: begin
                    if (jreq_s && y_lt_max_s && (rise_inc_s < MAX_RISE_C)) begin
                        y_d        = y_q + Y_WIDTH'(1'b1);
                        rise_cnt_d = rise_inc_s[RW-1:0];
                    end else begin
`ifdef PLAYER_HOVER_EN
                        state_d   = ST_HOVER;
                        hov_cnt_d = HOV_LOAD;
`else
                        state_d   = ST_FALLING;
`endif
                    end
                end
`ifdef PLAYER_HOVER_EN
                ST_HOVER: begin
                    if (hov_cnt_q == {HW{1'b0}}) begin
                        state_d = ST_FALLING;
                    end else begin
                        hov_cnt_d = hov_cnt_q - HW'(1'b1);
                    end
                end
`endif
                ST_FALLING: begin
                    if (support_s) begin
                        state_d  = ST_GROUNDED;
                        landed_d = 1'b1;
                    end else if (y_q != {Y_WIDTH{1'b0}}) begin
                        y_d = y_q - Y_WIDTH'(1'b1);
                    end else begin
                        y_d = y_q;
                    end
                end
                default: begin
                    state_d = ST_GROUNDED;
                end
            endcase
        end else begin
            jump_d = jump_q | jump;
        end
    end

    // Output decode from registered state.
    always_comb begin
        y           = y_q;
        on_platform = (state_q == ST_GROUNDED);
        landed      = landed_q;
    end

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed self-checking bench for player_motion_ctrl; expectations follow the
// PLAYER_HOVER_EN setting of the build.
module tb_player_motion_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       jump = 1'b0;
    logic       platform_below = 1'b0;
    logic [3:0] y, hi_y;
    logic       on_platform, landed, hi_on, hi_landed;

    int n_vec = 0;
    int n_err = 0;

`ifdef PLAYER_HOVER_EN
    localparam bit HOV_EN = 1'b1;
    localparam int FJ_N = 12;
    int fj_y[12] = '{1, 2, 3, 4, 4, 4, 4, 3, 2, 1, 0, 0};
`else
    localparam bit HOV_EN = 1'b0;
    localparam int FJ_N = 10;
    int fj_y[10] = '{1, 2, 3, 4, 4, 3, 2, 1, 0, 0};
`endif

    always #5 clk = ~clk;

    player_motion_ctrl #(.Y_WIDTH(4), .START_Y(0), .Y_MAX(15), .MAX_RISE(4), .HOVER_TICKS(2)) u_dut (
        .clk(clk), .reset(reset), .tick(tick), .jump(jump), .platform_below(platform_below),
        .y(y), .on_platform(on_platform), .landed(landed)
    );

    player_motion_ctrl #(.Y_WIDTH(4), .START_Y(14), .Y_MAX(15), .MAX_RISE(4), .HOVER_TICKS(2)) u_hi (
        .clk(clk), .reset(reset), .tick(tick), .jump(jump), .platform_below(platform_below),
        .y(hi_y), .on_platform(hi_on), .landed(hi_landed)
    );

    task automatic do_tick(input logic j);
        tick = 1'b1; jump = j;
        @(posedge clk); #1;
        tick = 1'b0; jump = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0; tick = 1'b0; jump = 1'b0; platform_below = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; tick = 1'b1; jump = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; tick = 1'b0; jump = 1'b0;
        n_vec++; if (y !== 4'd0) begin n_err++; $display("FAIL reset_y: got %0d expected 0", y); end
        n_vec++; if (on_platform !== 1'b1) begin n_err++; $display("FAIL reset_on: got %b expected 1", on_platform); end
        n_vec++; if (landed !== 1'b0) begin n_err++; $display("FAIL reset_landed: got %b expected 0", landed); end
        n_vec++; if (hi_y !== 4'd14) begin n_err++; $display("FAIL reset_hi_y: got %0d expected 14", hi_y); end
        do_tick(1'b0);
        n_vec++; if (y !== 4'd0 || on_platform !== 1'b1) begin
            n_err++; $display("FAIL idle_tick: got y=%0d on=%b expected y=0 on=1", y, on_platform);
        end
    endtask

    task automatic test_full_jump();
        apply_reset();
        for (int i = 0; i < FJ_N; i++) begin
            do_tick(i < 6);
            n_vec++;
            if (y !== 4'(fj_y[i]) || on_platform !== (i == FJ_N - 1) || landed !== (i == FJ_N - 1)) begin
                n_err++;
                $display("FAIL full_jump[%0d]: got y=%0d on=%b landed=%b expected y=%0d on=%b landed=%b",
                         i, y, on_platform, landed, fj_y[i], (i == FJ_N - 1), (i == FJ_N - 1));
            end
        end
        idle();
        n_vec++; if (landed !== 1'b0 || on_platform !== 1'b1) begin
            n_err++; $display("FAIL landed_width: got landed=%b on=%b expected landed=0 on=1", landed, on_platform);
        end
    endtask

    task automatic test_jump_pulse();
        apply_reset();
        jump = 1'b1; idle(); jump = 1'b0;
        n_vec++; if (y !== 4'd0 || on_platform !== 1'b1) begin
            n_err++; $display("FAIL pulse_hold: got y=%0d on=%b expected y=0 on=1", y, on_platform);
        end
        idle();
        do_tick(1'b0);
        n_vec++; if (y !== 4'd1 || on_platform !== 1'b0) begin
            n_err++; $display("FAIL pulse_rise: got y=%0d on=%b expected y=1 on=0", y, on_platform);
        end
        do_tick(1'b0);
        n_vec++; if (y !== 4'd1) begin n_err++; $display("FAIL pulse_apex: got y=%0d expected 1", y); end
        do_tick(1'b0);
        n_vec++; if (y !== (HOV_EN ? 4'd1 : 4'd0)) begin
            n_err++; $display("FAIL pulse_after_apex: got y=%0d expected %0d", y, (HOV_EN ? 1 : 0));
        end
    endtask

    task automatic test_platform();
        int n2;
        apply_reset();
        n2 = HOV_EN ? 9 : 7;
        for (int i = 0; i < n2; i++) do_tick(i < 6);
        n_vec++; if (y !== 4'd2 || on_platform !== 1'b0) begin
            n_err++; $display("FAIL plat_pre: got y=%0d on=%b expected y=2 on=0", y, on_platform);
        end
        platform_below = 1'b1;
        do_tick(1'b0);
        n_vec++; if (y !== 4'd2 || on_platform !== 1'b1 || landed !== 1'b1) begin
            n_err++; $display("FAIL plat_land: got y=%0d on=%b landed=%b expected y=2 on=1 landed=1", y, on_platform, landed);
        end
        do_tick(1'b0);
        n_vec++; if (y !== 4'd2 || on_platform !== 1'b1 || landed !== 1'b0) begin
            n_err++; $display("FAIL plat_stay: got y=%0d on=%b landed=%b expected y=2 on=1 landed=0", y, on_platform, landed);
        end
        platform_below = 1'b0;
        do_tick(1'b0);
        n_vec++; if (y !== 4'd2 || on_platform !== 1'b0) begin
            n_err++; $display("FAIL plat_walkoff: got y=%0d on=%b expected y=2 on=0", y, on_platform);
        end
        do_tick(1'b0);
        n_vec++; if (y !== 4'd1) begin n_err++; $display("FAIL plat_fall1: got y=%0d expected 1", y); end
        do_tick(1'b0);
        n_vec++; if (y !== 4'd0 || on_platform !== 1'b0) begin
            n_err++; $display("FAIL plat_fall0: got y=%0d on=%b expected y=0 on=0", y, on_platform);
        end
        do_tick(1'b0);
        n_vec++; if (y !== 4'd0 || on_platform !== 1'b1 || landed !== 1'b1) begin
            n_err++; $display("FAIL plat_floor: got y=%0d on=%b landed=%b expected y=0 on=1 landed=1", y, on_platform, landed);
        end
    endtask

    task automatic test_ceiling();
        int guard;
        apply_reset();
        do_tick(1'b1);
        n_vec++; if (hi_y !== 4'd15 || hi_on !== 1'b0) begin
            n_err++; $display("FAIL ceil_rise: got y=%0d on=%b expected y=15 on=0", hi_y, hi_on);
        end
        do_tick(1'b1);
        n_vec++; if (hi_y !== 4'd15) begin n_err++; $display("FAIL ceil_hold: got y=%0d expected 15", hi_y); end
        do_tick(1'b1);
        n_vec++; if (hi_y !== (HOV_EN ? 4'd15 : 4'd14)) begin
            n_err++; $display("FAIL ceil_next: got y=%0d expected %0d", hi_y, (HOV_EN ? 15 : 14));
        end
        guard = 0;
        while (!hi_on && guard < 25) begin do_tick(1'b0); guard++; end
        n_vec++; if (hi_on !== 1'b1 || hi_y !== 4'd0 || hi_landed !== 1'b1) begin
            n_err++; $display("FAIL ceil_land: got y=%0d on=%b landed=%b after %0d ticks expected y=0 on=1 landed=1",
                              hi_y, hi_on, hi_landed, guard);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        tick = 1'b1; jump = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            n_vec++; if (y !== 4'(i)) begin n_err++; $display("FAIL b2b[%0d]: got y=%0d expected %0d", i, y, i); end
        end
        tick = 1'b0; jump = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        do_tick(1'b1); do_tick(1'b1); do_tick(1'b1);
        n_vec++; if (y !== 4'd3) begin n_err++; $display("FAIL mid_pre: got y=%0d expected 3", y); end
        reset = 1'b0; tick = 1'b1; jump = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1; tick = 1'b0; jump = 1'b0;
        n_vec++; if (y !== 4'd0 || on_platform !== 1'b1 || landed !== 1'b0) begin
            n_err++; $display("FAIL mid_reset: got y=%0d on=%b landed=%b expected y=0 on=1 landed=0", y, on_platform, landed);
        end
        idle();
        do_tick(1'b0);
        n_vec++; if (y !== 4'd0 || on_platform !== 1'b1) begin
            n_err++; $display("FAIL mid_residual: got y=%0d on=%b expected y=0 on=1", y, on_platform);
        end
    endtask

    initial begin
        test_reset();
        test_full_jump();
        test_jump_pulse();
        test_platform();
        test_ceiling();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
